// File: rtl/bp_me_wormhole_packet_assembler.sv
// Wormhole receive-side packet assembler: gathers a header flit plus len body
// flits into one zero-padded wide buffer and presents it on a valid/yumi port.
module bp_me_wormhole_packet_assembler #(
   parameter int flit_width_p     = 64,
   parameter int cord_width_p     = 7,
   parameter int len_width_p      = 4,
   parameter int max_body_flits_p = 8
) (
   input  logic                                          clk_i,
   input  logic                                          reset_n_i,
   input  logic [flit_width_p-1:0]                       link_data_i,
   input  logic                                          link_v_i,
   output logic                                          link_ready_and_o,
   output logic [flit_width_p*(max_body_flits_p+1)-1:0]  pkt_o,
   output logic [len_width_p-1:0]                        pkt_len_o,
   output logic                                          pkt_v_o,
   input  logic                                          pkt_yumi_i,
   output logic                                          oversize_o
);

   localparam int pkt_width_lp = flit_width_p * (max_body_flits_p + 1);
   localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_body_flits_p);
   localparam logic [len_width_p-1:0] one_lp     = len_width_p'(1);

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_body  = 2'd1,
      e_out   = 2'd2,
      e_drain = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [len_width_p-1:0]  cnt_q, cnt_d;
   logic [len_width_p-1:0]  len_q, len_d;
   logic [pkt_width_lp-1:0] pkt_q, pkt_d;
   logic                    oversize_q, oversize_d;
   logic                    xfer_s;
   logic [len_width_p-1:0]  hdr_len_s;

   assign hdr_len_s = link_data_i[cord_width_p +: len_width_p];
   // Ready is a decode of the state flop, forced low while reset is held.
   assign link_ready_and_o = reset_n_i & (state_q != e_out);
   assign xfer_s           = link_v_i & link_ready_and_o;

   assign pkt_o      = pkt_q;
   assign pkt_len_o  = len_q;
   assign pkt_v_o    = (state_q == e_out);
   assign oversize_o = oversize_q;

   // Next-state, counter and packet-buffer update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      pkt_d      = pkt_q;
      oversize_d = oversize_q;
      case (state_q)
         e_idle: begin
            if (xfer_s) begin
               pkt_d                      = '0;
               pkt_d[flit_width_p-1:0]    = link_data_i;
               len_d                      = hdr_len_s;
               if (hdr_len_s == '0) begin
                  state_d = e_out;
               end else if (hdr_len_s <= max_len_lp) begin
                  cnt_d   = '0;
                  state_d = e_body;
               end else begin
                  // Too long for the buffer: swallow the body so the network keeps moving.
                  cnt_d      = hdr_len_s;
                  oversize_d = 1'b1;
                  state_d    = e_drain;
               end
            end else begin
               state_d = e_idle;
            end
         end
         e_body: begin
            if (xfer_s) begin
               for (int k = 0; k < max_body_flits_p; k++) begin
                  if (cnt_q == len_width_p'(k)) begin
                     pkt_d[(k+1)*flit_width_p +: flit_width_p] = link_data_i;
                  end else begin
                     pkt_d[(k+1)*flit_width_p +: flit_width_p] = pkt_q[(k+1)*flit_width_p +: flit_width_p];
                  end
               end
               cnt_d = cnt_q + one_lp;
               if ((cnt_q + one_lp) == len_q) begin
                  state_d = e_out;
               end else begin
                  state_d = e_body;
               end
            end else begin
               state_d = e_body;
            end
         end
         e_out: begin
            if (pkt_yumi_i) begin
               state_d = e_idle;
            end else begin
               state_d = e_out;
            end
         end
         e_drain: begin
            if (xfer_s) begin
               cnt_d = cnt_q - one_lp;
               if (cnt_q == one_lp) begin
                  state_d = e_idle;
               end else begin
                  state_d = e_drain;
               end
            end else begin
               state_d = e_drain;
            end
         end
         default: begin
            state_d = e_idle;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= e_idle;
         cnt_q      <= '0;
         len_q      <= '0;
         pkt_q      <= '0;
         oversize_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         pkt_q      <= pkt_d;
         oversize_q <= oversize_d;
      end
   end

endmodule

// File: tb/tb_bp_me_wormhole_packet_assembler.sv
// Self-checking bench: table-driven packets, a mid-packet reset and random
// flit traffic, all compared each cycle against a flit-stream reference model.
module tb_bp_me_wormhole_packet_assembler;

   localparam int W    = 64;
   localparam int MAXB = 8;
   localparam int PW   = W * (MAXB + 1);

   logic          clk_i;
   logic          reset_n_i;
   logic [W-1:0]  link_data_i;
   logic          link_v_i;
   logic          link_ready_and_o;
   logic [PW-1:0] pkt_o;
   logic [3:0]    pkt_len_o;
   logic          pkt_v_o;
   logic          pkt_yumi_i;
   logic          oversize_o;

   bp_me_wormhole_packet_assembler #(
      .flit_width_p(64), .cord_width_p(7), .len_width_p(4), .max_body_flits_p(8)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .link_data_i(link_data_i), .link_v_i(link_v_i), .link_ready_and_o(link_ready_and_o),
      .pkt_o(pkt_o), .pkt_len_o(pkt_len_o), .pkt_v_o(pkt_v_o),
      .pkt_yumi_i(pkt_yumi_i), .oversize_o(oversize_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int          len;
      int          cord;
      int          gap;
      int          ydelay;
      int          exp_lat;
      logic [63:0] base;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   int tx;

   // Reference model: the flits of the packet in flight, the expected buffer,
   // and whether a finished packet is waiting for the consumer.
   logic          m_hold;
   logic          m_ovs;
   logic [PW-1:0] m_pkt;
   logic [3:0]    m_len;
   logic [W-1:0]  cur[$];

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 1'b0;
      m_ovs  = 1'b0;
      m_pkt  = '0;
      m_len  = 4'd0;
      cur.delete();
   endtask

   task automatic check_outputs();
      chk("ready", link_ready_and_o, reset_n_i && !m_hold);
      chk("pkt_v", pkt_v_o, m_hold);
      chk("oversize", oversize_o, m_ovs);
      chk("pkt_len", pkt_len_o, m_len);
      chk("pkt", pkt_o, m_pkt);
   endtask

   task automatic step_cycle(input logic v, input logic [W-1:0] d, input logic y);
      logic xf;
      int   L;
      link_v_i    = v;
      link_data_i = d;
      pkt_yumi_i  = y;
      xf = v && !m_hold;
      @(posedge clk_i);
      if (xf) begin
         tx++;
         cur.push_back(d);
         L = int'(cur[0][10:7]);
         if (cur.size() == 1) begin
            m_pkt       = '0;
            m_pkt[63:0] = d;
            m_len       = cur[0][10:7];
            if (L > MAXB) m_ovs = 1'b1;
         end else if (L <= MAXB) begin
            m_pkt[(cur.size()-1)*W +: W] = d;
         end
         if (cur.size() == L + 1) begin
            cur.delete();
            if (L <= MAXB) m_hold = 1'b1;
         end
      end else if (y && m_hold) begin
         m_hold = 1'b0;
      end
      #1;
      check_outputs();
   endtask

   task automatic send_pkt(input vec_t t);
      logic [W-1:0] hdr;
      logic [W-1:0] fl;
      int lat;
      int steps;
      hdr        = {$urandom, $urandom};
      hdr[10:7]  = t.len[3:0];
      hdr[6:0]   = t.cord[6:0];
      tx    = 0;
      lat   = 0;
      steps = 0;
      for (int i = 0; i <= t.len; i++) begin
         if (i >= 2) begin
            for (int g = 0; g < t.gap; g++) begin
               step_cycle(1'b0, {$urandom, $urandom}, 1'b0);
               steps++;
               if (pkt_v_o && lat == 0) lat = steps;
            end
         end
         fl = (i == 0) ? hdr : (t.base + 64'(i) - 64'd1);
         step_cycle(1'b1, fl, 1'b0);
         steps++;
         if (pkt_v_o && lat == 0) lat = steps;
      end
      chk("xfers", tx, t.len + 1);
      chk("latency", lat, t.exp_lat);
      if (t.len <= MAXB) begin
         for (int h = 0; h < t.ydelay; h++) step_cycle(1'b1, {$urandom, $urandom}, 1'b0);
         chk("xfers_hold", tx, t.len + 1);
         step_cycle(1'b0, '0, 1'b1);
      end
   endtask

   task automatic async_reset();
      #2 reset_n_i = 1'b0;
      #1 model_reset();
      check_outputs();
      @(posedge clk_i);
      #1 check_outputs();
      reset_n_i = 1'b1;
      #1 check_outputs();
   endtask

   vec_t vecs[8];
   vec_t v1;

   initial begin
      vecs[0] = '{len: 0,  cord: 5, gap: 0, ydelay: 0, exp_lat: 1,  base: 64'h0};
      vecs[1] = '{len: 3,  cord: 1, gap: 0, ydelay: 0, exp_lat: 4,  base: 64'hA};
      vecs[2] = '{len: 2,  cord: 2, gap: 2, ydelay: 5, exp_lat: 5,  base: 64'h20};
      vecs[3] = '{len: 10, cord: 3, gap: 0, ydelay: 0, exp_lat: 0,  base: 64'h30};
      vecs[4] = '{len: 1,  cord: 4, gap: 0, ydelay: 1, exp_lat: 2,  base: 64'h40};
      vecs[5] = '{len: 8,  cord: 6, gap: 0, ydelay: 0, exp_lat: 9,  base: 64'h50};
      vecs[6] = '{len: 15, cord: 7, gap: 1, ydelay: 0, exp_lat: 0,  base: 64'h60};
      vecs[7] = '{len: 9,  cord: 8, gap: 0, ydelay: 2, exp_lat: 0,  base: 64'h70};
      v1      = '{len: 1,  cord: 9, gap: 0, ydelay: 0, exp_lat: 2,  base: 64'hBEEF};

      reset_n_i   = 1'b0;
      link_v_i    = 1'b0;
      link_data_i = '0;
      pkt_yumi_i  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 check_outputs();
      reset_n_i = 1'b1;
      #1 check_outputs();

      for (int i = 0; i < 8; i++) send_pkt(vecs[i]);

      // Reset in the middle of a len=4 packet, then a fresh len=1 packet.
      step_cycle(1'b1, 64'h0000_1234_0000_0201, 1'b0);
      step_cycle(1'b1, 64'h1111, 1'b0);
      step_cycle(1'b1, 64'h2222, 1'b0);
      async_reset();
      send_pkt(v1);

      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] d;
         d       = {$urandom, $urandom};
         d[10:7] = 4'($urandom_range(0, 11));
         if (i == 300) async_reset();
         step_cycle($urandom_range(0, 3) != 0, d, m_hold && ($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_me_wormhole_packet_assembler.md
# bp_me_wormhole_packet_assembler

Receive-side packet assembler between the tile-side ready&valid output of a coherence or DMA network socket and an LCE/CCE message consumer. It accepts wormhole flits (one header flit plus `len` body flits), gathers them into one wide, zero-padded packet buffer, and presents the whole packet on a valid/yumi interface. Packets whose length exceeds the buffer are drained from the network and flagged rather than stalling the network. One assembler serves one network.

## Interface
- `flit_width_p`, 64: width of one wormhole flit.
- `cord_width_p`, 7: width of the destination coordinate field in header bits [cord_width_p-1:0].
- `len_width_p`, 4: width of the length field in header bits [cord_width_p +: len_width_p]; the field holds the number of body flits.
- `max_body_flits_p`, 8: body flits the buffer holds; packet width = flit_width_p*(max_body_flits_p+1).

Ports:
- `clk_i`, input, 1: clock.
- `reset_n_i`, input, 1: reset, asynchronous, active-low.
- `link_data_i`, input, flit_width_p: incoming flit.
- `link_v_i`, input, 1: flit valid.
- `link_ready_and_o`, output, 1: assembler accepts a flit this cycle (ready&valid handshake).
- `pkt_o`, output, flit_width_p*(max_body_flits_p+1): packet; header in flit slot 0, body flit k in slot k+1.
- `pkt_len_o`, output, len_width_p: body-flit count of the presented packet.
- `pkt_v_o`, output, 1: packet valid.
- `pkt_yumi_i`, input, 1: consumer takes the packet; legal only while pkt_v_o=1.
- `oversize_o`, output, 1: sticky flag, set when an oversize packet was dropped.

## Operation
- A flit transfers when link_v_i & link_ready_and_o.
- `link_ready_and_o` = 1 in e_idle, e_body and e_drain. It is 0 in e_out and while reset is asserted. It has no combinational dependence on pkt_yumi_i.
- The FSM has four states: e_idle, e_body, e_out, e_drain.
- **e_idle**, header transfer:
  - Capture the header into slot 0, zero slots 1..max, and latch len.
  - len=0: go to e_out.
  - 1 ≤ len ≤ max_body_flits_p: clear the counter and go to e_body.
  - len > max_body_flits_p: load the counter with len, go to e_drain, set oversize_o.
- **e_body**, each transfer:
  - Write the flit into slot cnt+1, then increment cnt.
  - When cnt+1 == len, go to e_out.
- **e_out**:
  - pkt_v_o = 1; pkt_o and pkt_len_o are held stable.
  - On pkt_yumi_i, go to e_idle.
- **e_drain**, each transfer:
  - Discard the flit and decrement the counter.
  - When the counter reaches 1 on a transfer, go to e_idle.
  - No packet is produced.
- The counter is len_width_p bits and never wraps. The len comparison is unsigned.
- `oversize_o` is sticky until reset.
- Unused body slots always read as 0.
- `pkt_yumi_i` outside e_out is ignored.

## Timing
- Reset (reset_n_i low, asynchronous) puts outputs at: state e_idle, pkt_v_o=0, pkt_o=0, pkt_len_o=0, oversize_o=0, link_ready_and_o=0. Counter = 0.
- The first cycle after deassertion has link_ready_and_o=1.
- Latency: if the header transfers at cycle N and body flits arrive back-to-back, pkt_v_o rises at N+L+1. A len=0 packet gives pkt_v_o at N+1.
- Yumi at cycle M puts pkt_v_o=0 and link_ready_and_o=1 at M+1.
- Minimum per-packet interval is L+2 cycles.
- A link_v_i gap in e_body or e_drain stalls the FSM; the partial state is kept.
- Reset asserted mid-packet discards the partial packet immediately. The next flit after release is treated as a header.
- pkt_o changes only on the header/body writes in e_idle and e_body.

## Test plan
- **Header-only packet**: header 0x...0005 with len=0 and cord=5 → pkt_v_o at N+1, pkt_len_o=0, slot 0 = header, slots 1..8 = 0. Yumi → ready at the next cycle.
- **Three-flit body, back-to-back**: header len=3, then body flits 0xA, 0xB, 0xC → pkt_v_o at N+4, slots 1..3 = A, B, C, slots 4..8 = 0, pkt_len_o=3.
- **Bubbles and backpressure**: len=2 with link_v_i low for 2 cycles between the body flits; consumer delays yumi by 5 cycles → packet content is identical, link_ready_and_o stays 0 for the whole hold, and exactly 3 transfers occur.
- **Oversize drain**: len=10 with max=8 → 11 flits are consumed, pkt_v_o is never asserted, oversize_o=1 from N+1 onward. The following len=1 packet is assembled correctly.
- **Full buffer**: len=8 → all 9 slots are filled and pkt_v_o is asserted at N+9.
- **Reset mid-packet**: reset_n_i pulsed low after header len=4 and 2 body flits → outputs return to reset values asynchronously. The next len=1 packet presents the correct data with stale slots equal to 0.
